// File: rtl/nf_pkg.sv
// rtl/nf_pkg.sv - shared state encoding, frame length limits and byte-lane helpers for the packet generator
package nf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [10:0] MIN_FRAME_LEN = 11'd60;
    localparam logic [10:0] MAX_FRAME_LEN = 11'd1514;

    // DST(6) + SRC(6) + EtherType(2) + signature(8) + seq(4)
    localparam logic [10:0] HDR_BYTES = 11'd26;

    function automatic logic [10:0] clamp_len(input logic [10:0] len,
                                              input logic [10:0] lo,
                                              input logic [10:0] hi);
        logic [10:0] r;
        r = len;
        if (len < lo) r = lo;
        if (len > hi) r = hi;
        return r;
    endfunction

    // Frame byte n travels on lane n%8, i.e. bits [8*lane+7 : 8*lane].
    function automatic logic [63:0] place_byte(input logic [63:0] word,
                                               input logic [2:0]  lane,
                                               input logic [7:0]  b);
        logic [63:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/nf_pktgen_ng_if.sv
// rtl/nf_pktgen_ng_if.sv - 64-bit AXI-Stream TX bundle between the generator and the MAC
interface nf_pktgen_ng_if;

    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/nf_pktgen_beat.sv
// rtl/nf_pktgen_beat.sv - combinational formatter producing tdata/tkeep/tlast for one beat of a frame
module nf_pktgen_beat
    import nf_pkg::*;
#(
    parameter logic [47:0] SRC_MAC  = 48'h3ca9f457afde,
    parameter logic [47:0] DST_MAC  = 48'h3ca9f457aade,
    parameter logic [15:0] ETH_TYPE = 16'h0800,
    parameter logic [63:0] PAYLOAD  = 64'hf00d_face_d066_f00d
) (
    input  logic [7:0]  beat_idx,
    input  logic [10:0] frame_len,
    input  logic [31:0] seq,
    output logic [63:0] tdata,
    output logic [7:0]  tkeep,
    output logic        tlast
);

    logic [207:0] hdr;
    logic [7:0]   last_idx;
    logic [2:0]   rem;
    logic [10:0]  byte_idx;
    logic [7:0]   hdr_pos;

    // Header bytes 0..25 in transmit order, byte 0 in the top octet.
    assign hdr = {DST_MAC, SRC_MAC, ETH_TYPE, PAYLOAD, seq};
    assign rem = frame_len[2:0];

    always_comb begin
        last_idx = 8'((frame_len - 11'd1) >> 3);
        tlast    = (beat_idx == last_idx);
        tkeep    = 8'hFF;
        if (tlast && rem != 3'd0) begin
            tkeep = 8'hFF >> (4'd8 - {1'b0, rem});
        end
    end

    always_comb begin
        tdata    = '0;
        byte_idx = '0;
        hdr_pos  = '0;
        for (int i = 0; i < 8; i++) begin
            byte_idx = {beat_idx, i[2:0]};
            hdr_pos  = 8'd200 - {byte_idx[4:0], 3'b000};
            if (byte_idx < frame_len) begin
                if (byte_idx < HDR_BYTES) begin
                    tdata = place_byte(tdata, i[2:0], hdr[hdr_pos +: 8]);
                end else begin
                    tdata = place_byte(tdata, i[2:0], byte_idx[7:0]);
                end
            end
        end
    end

endmodule

// File: rtl/nf_pktgen_ng.sv
// rtl/nf_pktgen_ng.sv - runtime-configurable Ethernet II frame generator driving the 10G MAC TX stream
module nf_pktgen_ng
    import nf_pkg::*;
#(
    parameter logic [47:0] SRC_MAC  = 48'h3ca9f457afde,
    parameter logic [47:0] DST_MAC  = 48'h3ca9f457aade,
    parameter logic [15:0] ETH_TYPE = 16'h0800,
    parameter logic [63:0] PAYLOAD  = 64'hf00d_face_d066_f00d,
    parameter int          GAP_W    = 26,
    parameter logic [10:0] MIN_LEN  = MIN_FRAME_LEN,
    parameter logic [10:0] MAX_LEN  = MAX_FRAME_LEN
) (
    input  logic               clk156,
    input  logic               reset,
    input  logic               cfg_enable,
    input  logic [10:0]        cfg_frame_len,
    input  logic [GAP_W-1:0]   cfg_gap,
    input  logic [31:0]        cfg_count,
    nf_pktgen_ng_if.master     s_axis_tx,
    output logic [7:0]         tx_ifg_delay,
    output logic               busy,
    output logic               done,
    output logic [31:0]        frames_sent
);

    state_e           state_q, state_d;
    logic [7:0]       beat_q, beat_d;
    logic [10:0]      len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      seq_q, seq_d;
    logic [31:0]      frames_q, frames_d;

    logic             start_frame;
    logic             tvalid;
    logic             accept;
    logic [63:0]      beat_data;
    logic [7:0]       beat_keep;
    logic             beat_last;

    assign tvalid = (state_q == SEND);
    assign accept = tvalid & s_axis_tx.tready;

    nf_pktgen_beat #(
        .SRC_MAC  (SRC_MAC),
        .DST_MAC  (DST_MAC),
        .ETH_TYPE (ETH_TYPE),
        .PAYLOAD  (PAYLOAD)
    ) u_beat (
        .beat_idx  (beat_q),
        .frame_len (len_q),
        .seq       (seq_q),
        .tdata     (beat_data),
        .tkeep     (beat_keep),
        .tlast     (beat_last)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        len_d       = len_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        count_d     = count_q;
        seq_d       = seq_q;
        frames_d    = frames_q;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_enable) begin
                    state_d     = SEND;
                    start_frame = 1'b1;
                end
            end
            SEND: begin
                if (accept) begin
                    if (beat_last) begin
                        seq_d    = seq_q + 32'd1;
                        frames_d = frames_q + 32'd1;
                        if (count_q != '0 && frames_d == count_q) begin
                            state_d = DONE;
                        end else if (!cfg_enable) begin
                            state_d = IDLE;
                        end else if (gap_q == '0) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q - GAP_W'(1);
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    if (cfg_enable) begin
                        state_d     = SEND;
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                // A finished run restarts numbering only once software withdraws enable.
                if (!cfg_enable) begin
                    state_d  = IDLE;
                    seq_d    = '0;
                    frames_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame configuration is captured only here, so mid-frame edits never reshape a frame.
        if (start_frame) begin
            beat_d  = '0;
            len_d   = clamp_len(cfg_frame_len, MIN_LEN, MAX_LEN);
            gap_d   = cfg_gap;
            count_d = cfg_count;
        end
    end

    always_ff @(posedge clk156) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            len_q     <= MIN_LEN;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            count_q   <= '0;
            seq_q     <= '0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            count_q   <= count_d;
            seq_q     <= seq_d;
            frames_q  <= frames_d;
        end
    end

    assign s_axis_tx.tvalid = tvalid;
    assign s_axis_tx.tdata  = tvalid ? beat_data : 64'd0;
    assign s_axis_tx.tkeep  = tvalid ? beat_keep : 8'd0;
    assign s_axis_tx.tlast  = tvalid & beat_last;
    assign s_axis_tx.tuser  = 1'b0;

    assign tx_ifg_delay = 8'd8;
    assign busy         = (state_q == SEND) || (state_q == GAP);
    assign done         = (state_q == DONE);
    assign frames_sent  = frames_q;

endmodule

// File: tb/tb_nf_pktgen_ng.sv
// tb/tb_nf_pktgen_ng.sv - self-checking bench for nf_pktgen_ng against a frame-level reference model
module tb_nf_pktgen_ng;

    localparam logic [47:0] SRC_MAC  = 48'h3ca9f457afde;
    localparam logic [47:0] DST_MAC  = 48'h3ca9f457aade;
    localparam logic [15:0] ETH_TYPE = 16'h0800;
    localparam logic [63:0] PAYLOAD  = 64'hf00d_face_d066_f00d;
    localparam int          GAP_W    = 26;

    logic             clk156 = 1'b0;
    logic             reset;
    logic             cfg_enable;
    logic [10:0]      cfg_frame_len;
    logic [GAP_W-1:0] cfg_gap;
    logic [31:0]      cfg_count;
    logic [7:0]       tx_ifg_delay;
    logic             busy;
    logic             done;
    logic [31:0]      frames_sent;

    nf_pktgen_ng_if axis_if ();

    nf_pktgen_ng dut (
        .clk156        (clk156),
        .reset         (reset),
        .cfg_enable    (cfg_enable),
        .cfg_frame_len (cfg_frame_len),
        .cfg_gap       (cfg_gap),
        .cfg_count     (cfg_count),
        .s_axis_tx     (axis_if),
        .tx_ifg_delay  (tx_ifg_delay),
        .busy          (busy),
        .done          (done),
        .frames_sent   (frames_sent)
    );

    always #5 clk156 = ~clk156;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_l(input int l);
        return (l < 60) ? 60 : ((l > 1514) ? 1514 : l);
    endfunction

    function automatic logic [7:0] exp_byte(input int n, input logic [31:0] seq);
        if (n < 6)  return 8'(DST_MAC >> (8 * (5 - n)));
        if (n < 12) return 8'(SRC_MAC >> (8 * (11 - n)));
        if (n < 14) return 8'(ETH_TYPE >> (8 * (13 - n)));
        if (n < 22) return 8'(PAYLOAD >> (8 * (21 - n)));
        if (n < 26) return 8'(seq >> (8 * (25 - n)));
        return 8'(n);
    endfunction

    // Reference model state: what the stream must look like, advanced on each accepted beat.
    logic [31:0] m_seq = '0;
    logic [31:0] m_frames = '0;
    logic        m_done = 1'b0;
    int          m_beat = 0;
    int          frames_seen = 0;
    int          cap_beats = 0;
    logic [63:0] cap_data [256];
    logic [7:0]  cap_keep [256];
    bit          gap_armed = 1'b0;
    int          idle_cnt = 0;
    int          gap_exp = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic [7:0]  prev_keep = '0;
    logic        prev_last = 1'b0;
    bit          rst_prev = 1'b0;
    bit          tready_rand = 1'b0;

    always @(negedge clk156) begin
        int          len;
        int          n;
        logic [63:0] ed;
        logic [63:0] mask;
        logic [7:0]  ek;
        logic        el;
        bit          done_clear;

        done_clear = m_done && !cfg_enable && !reset;

        check("tuser", 64'(axis_if.tuser), 64'd0);
        check("ifg_delay", 64'(tx_ifg_delay), 64'd8);
        check("frames_sent", 64'(frames_sent), 64'(m_frames));
        check("done", 64'(done), 64'(m_done));
        if (rst_prev) check("tvalid_after_reset", 64'(axis_if.tvalid), 64'd0);

        if (axis_if.tvalid === 1'b1) begin
            check("busy_in_send", 64'(busy), 64'd1);
            if (prev_stall) begin
                check("stall_tdata", axis_if.tdata, prev_data);
                check("stall_tkeep", 64'(axis_if.tkeep), 64'(prev_keep));
                check("stall_tlast", 64'(axis_if.tlast), 64'(prev_last));
            end
            if (gap_armed) begin
                check("idle_gap", 64'(idle_cnt), 64'(gap_exp));
                gap_armed = 1'b0;
            end
            len  = clamp_l(int'(cfg_frame_len));
            ek   = '0;
            ed   = '0;
            mask = '0;
            for (int i = 0; i < 8; i++) begin
                n = 8 * m_beat + i;
                if (n < len) begin
                    ek[i]         = 1'b1;
                    ed[8*i +: 8]   = exp_byte(n, m_seq);
                    mask[8*i +: 8] = 8'hFF;
                end
            end
            el = (8 * m_beat + 8 >= len);
            if (axis_if.tready === 1'b1 && !reset) begin
                check("beat_tdata", axis_if.tdata & mask, ed);
                check("beat_tkeep", 64'(axis_if.tkeep), 64'(ek));
                check("beat_tlast", 64'(axis_if.tlast), 64'(el));
                if (m_beat < 256) begin
                    cap_data[m_beat] = axis_if.tdata;
                    cap_keep[m_beat] = axis_if.tkeep;
                end
                if (el) begin
                    cap_beats = m_beat + 1;
                    m_beat    = 0;
                    m_seq     = m_seq + 32'd1;
                    m_frames  = m_frames + 32'd1;
                    frames_seen++;
                    gap_armed = 1'b1;
                    idle_cnt  = 0;
                    gap_exp   = int'(cfg_gap);
                    if (cfg_count != 0 && m_frames == cfg_count) begin
                        m_done    = 1'b1;
                        gap_armed = 1'b0;
                    end
                end else begin
                    m_beat++;
                end
            end
        end else if (gap_armed) begin
            idle_cnt++;
        end

        prev_stall = (axis_if.tvalid === 1'b1) && (axis_if.tready !== 1'b1) && !reset;
        prev_data  = axis_if.tdata;
        prev_keep  = axis_if.tkeep;
        prev_last  = axis_if.tlast;
        if (!cfg_enable) gap_armed = 1'b0;
        if (done_clear) begin
            m_done   = 1'b0;
            m_seq    = '0;
            m_frames = '0;
        end
        if (reset) begin
            m_seq      = '0;
            m_frames   = '0;
            m_done     = 1'b0;
            m_beat     = 0;
            gap_armed  = 1'b0;
            prev_stall = 1'b0;
        end
        rst_prev = reset;
    end

    initial begin
        axis_if.tready = 1'b1;
        forever begin
            @(posedge clk156);
            #1;
            axis_if.tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic start_run(input int len, input int gap, input int cnt, input bit rnd);
        @(posedge clk156);
        #1;
        cfg_frame_len = 11'(len);
        cfg_gap       = GAP_W'(gap);
        cfg_count     = 32'(cnt);
        tready_rand   = rnd;
        cfg_enable    = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk156);
            k++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic stop_run();
        @(posedge clk156);
        #1;
        cfg_enable  = 1'b0;
        tready_rand = 1'b0;
        repeat (3) @(negedge clk156);
    endtask

    task automatic do_reset();
        @(posedge clk156);
        #1;
        reset      = 1'b1;
        cfg_enable = 1'b0;
        repeat (2) @(posedge clk156);
        #1;
        reset = 1'b0;
        @(negedge clk156);
    endtask

    initial begin
        int base;
        int k;
        int vcnt;
        int len;
        int gap;
        int cnt;

        reset         = 1'b1;
        cfg_enable    = 1'b0;
        cfg_frame_len = 11'd60;
        cfg_gap       = '0;
        cfg_count     = 32'd1;
        repeat (3) @(posedge clk156);
        #1;
        reset = 1'b0;
        @(negedge clk156);
        check("reset_tvalid", 64'(axis_if.tvalid), 64'd0);
        check("reset_tdata", axis_if.tdata, 64'd0);
        check("reset_tkeep", 64'(axis_if.tkeep), 64'd0);
        check("reset_tlast", 64'(axis_if.tlast), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_frames", 64'(frames_sent), 64'd0);

        start_run(60, 0, 1, 1'b0);
        wait_done(200);
        check("min_beats", 64'(cap_beats), 64'd8);
        check("min_beat0_data", cap_data[0], 64'ha93c_deaa_57f4_a93c);
        check("min_last_keep", 64'(cap_keep[7]), 64'h0F);
        check("min_frames", 64'(frames_sent), 64'd1);
        stop_run();
        check("done_cleared", 64'(done), 64'd0);
        check("frames_cleared", 64'(frames_sent), 64'd0);

        start_run(64, 10, 3, 1'b0);
        wait_done(500);
        check("gap_beats", 64'(cap_beats), 64'd8);
        check("gap_last_keep", 64'(cap_keep[7]), 64'hFF);
        check("gap_frames", 64'(frames_sent), 64'd3);
        check("gap_seq_byte25", 64'(cap_data[3][15:8]), 64'd2);
        stop_run();

        start_run(100, 5, 2, 1'b1);
        wait_done(2000);
        check("stall_beats", 64'(cap_beats), 64'd13);
        check("stall_last_keep", 64'(cap_keep[12]), 64'h0F);
        check("stall_byte99", 64'(cap_data[12][31:24]), 64'h63);
        stop_run();

        start_run(20, 0, 1, 1'b0);
        wait_done(200);
        check("clamp_lo_beats", 64'(cap_beats), 64'd8);
        check("clamp_lo_keep", 64'(cap_keep[7]), 64'h0F);
        stop_run();
        start_run(2000, 0, 1, 1'b0);
        wait_done(1000);
        check("clamp_hi_beats", 64'(cap_beats), 64'd190);
        check("clamp_hi_keep", 64'(cap_keep[189]), 64'h03);
        stop_run();

        base = frames_seen;
        start_run(64, 0, 0, 1'b0);
        k = 0;
        while (!(frames_seen == base + 4 && m_beat == 3) && k < 2000) begin
            @(posedge clk156);
            k++;
        end
        check("drop_point_reached", 64'(frames_seen == base + 4 && m_beat == 3), 64'd1);
        #1;
        cfg_enable = 1'b0;
        k = 0;
        while (frames_seen < base + 5 && k < 500) begin
            @(posedge clk156);
            k++;
        end
        vcnt = 0;
        repeat (20) begin
            @(negedge clk156);
            if (axis_if.tvalid === 1'b1) vcnt++;
        end
        check("drop_frames_seen", 64'(frames_seen - base), 64'd5);
        check("drop_no_more_valid", 64'(vcnt), 64'd0);
        check("drop_frames_sent", 64'(frames_sent), 64'd5);
        check("drop_busy", 64'(busy), 64'd0);

        start_run(100, 0, 0, 1'b0);
        base = frames_seen;
        k = 0;
        while (!(frames_seen == base + 2 && m_beat == 4) && k < 2000) begin
            @(posedge clk156);
            k++;
        end
        check("reset_point_reached", 64'(frames_seen == base + 2 && m_beat == 4), 64'd1);
        #1;
        reset = 1'b1;
        @(posedge clk156);
        #1;
        reset = 1'b0;
        @(negedge clk156);
        check("midreset_tvalid", 64'(axis_if.tvalid), 64'd0);
        check("midreset_frames", 64'(frames_sent), 64'd0);
        base = frames_seen;
        k = 0;
        while (frames_seen < base + 1 && k < 500) begin
            @(posedge clk156);
            k++;
        end
        check("restart_frame_seen", 64'(frames_seen - base), 64'd1);
        check("restart_seq_hi", 64'(cap_data[2][63:48]), 64'd0);
        check("restart_seq_lo", 64'(cap_data[3][15:0]), 64'd0);
        stop_run();
        do_reset();

        for (int it = 0; it < 6; it++) begin
            len = int'($urandom_range(20, 300));
            gap = int'($urandom_range(0, 12));
            cnt = int'($urandom_range(1, 3));
            start_run(len, gap, cnt, 1'($urandom_range(0, 1)));
            wait_done(4000);
            check("rand_frames", 64'(frames_sent), 64'(cnt));
            check("rand_beats", 64'(cap_beats), 64'((clamp_l(len) + 7) / 8));
            stop_run();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
